// File: rtl/counter_display_ctrl.sv
// Free-running hex/BCD up/down counter with its own tick prescaler and a
// registered active-low seven-segment driver with optional leading-zero blanking.
module counter_display_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  up,
    input  logic                  bcd,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   value,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  wrap
);
    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned SW = 7 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [VW-1:0] value_q, value_d;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] seg_q, seg_d;

    logic [VW-1:0] hex_val, bcd_val, load_clamped;
    logic          hex_wrap, bcd_wrap;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Prescaler and registered terminal-count tick
    always_comb begin
        presc_d = (presc_q == PTERM) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_q == PTERM);
    end

    // Binary step
    always_comb begin
        hex_val  = up ? value_q + VW'(1) : value_q - VW'(1);
        hex_wrap = up ? (&value_q) : ~(|value_q);
    end

    // Decimal step: digits above 9 count as 9; carry/borrow ripples from digit 0
    always_comb begin
        logic       chain;
        logic [3:0] dig;
        bcd_val      = '0;
        load_clamped = '0;
        chain        = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dig = value_q[4*k +: 4];
            if (dig > 4'd9) begin
                dig = 4'd9;
            end
            bcd_val[4*k +: 4] = dig;
            if (chain) begin
                if (up) begin
                    if (dig == 4'd9) begin
                        bcd_val[4*k +: 4] = 4'd0;
                    end else begin
                        bcd_val[4*k +: 4] = dig + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        bcd_val[4*k +: 4] = 4'd9;
                    end else begin
                        bcd_val[4*k +: 4] = dig - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
            load_clamped[4*k +: 4] = (load_value[4*k +: 4] > 4'd9) ? 4'd9
                                                                   : load_value[4*k +: 4];
        end
        bcd_wrap = chain;
    end

    // Update priority: clear, then load, then a tick-qualified step
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = bcd ? load_clamped : load_value;
        end else if (tick_q && run) begin
            value_d = bcd ? bcd_val : hex_val;
            wrap_d  = bcd ? bcd_wrap : hex_wrap;
        end
    end

    // Segment decode, scanning from the top digit to find leading zeros
    always_comb begin
        logic       lz;
        logic [3:0] dig;
        seg_d = '1;
        lz    = (BLANK_LZ != 0);
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            dig = value_q[4*k +: 4];
            if (dig != 4'd0) begin
                lz = 1'b0;
            end
            if (lz && (k != 0)) begin
                seg_d[7*k +: 7] = 7'h7F;
            end else begin
                seg_d[7*k +: 7] = glyph(dig);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            value_q <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign value = value_q;
    assign seg   = seg_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_display_ctrl.sv
// Bench for counter_display_ctrl: directed steps plus random traffic, checked
// cycle by cycle against a decimal/modular arithmetic reference model.
module tb_counter_display_ctrl;
    localparam int unsigned DIGITS   = 2;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned VW       = 4 * DIGITS;
    localparam int unsigned SW       = 7 * DIGITS;
    localparam int          HMOD     = 1 << VW;
    localparam int          DMOD     = 10 ** DIGITS;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0, up = 1'b1, bcd = 1'b0, clear = 1'b0, load = 1'b0;
    logic [VW-1:0] load_value = '0;
    logic [VW-1:0] value, value_nb;
    logic [SW-1:0] seg, seg_nb;
    logic          tick, wrap, tick_nb, wrap_nb;

    int            tests = 0;
    int            fails = 0;
    int            m_val, cyc, n_wait;
    bit            m_tick, m_wrap;
    logic [SW-1:0] m_seg, m_seg_nb;
    logic [6:0]    glyph [16];

    counter_display_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_LZ(1)) dut (
        .clock(clock), .reset(reset), .run(run), .up(up), .bcd(bcd),
        .clear(clear), .load(load), .load_value(load_value),
        .value(value), .seg(seg), .tick(tick), .wrap(wrap)
    );

    counter_display_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_LZ(0)) dut_nb (
        .clock(clock), .reset(reset), .run(run), .up(up), .bcd(bcd),
        .clear(clear), .load(load), .load_value(load_value),
        .value(value_nb), .seg(seg_nb), .tick(tick_nb), .wrap(wrap_nb)
    );

    always #5 clock = ~clock;

    // Decimal number represented by v, digits above 9 read as 9
    function automatic int to_dec(input int v);
        int n;
        n = 0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            int d;
            d = (v >> (4 * k)) & 15;
            if (d > 9) d = 9;
            n = n * 10 + d;
        end
        return n;
    endfunction

    function automatic int to_bcd(input int n);
        int v, r;
        v = 0;
        r = n;
        for (int k = 0; k < int'(DIGITS); k++) begin
            v = v | ((r % 10) << (4 * k));
            r = r / 10;
        end
        return v;
    endfunction

    // Digit k>0 is blank when the whole value fits below it
    function automatic logic [SW-1:0] seg_of(input int v, input bit blank);
        logic [SW-1:0] s;
        s = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (blank && k > 0 && v < (1 << (4 * k))) s[7*k +: 7] = 7'h7F;
            else                                      s[7*k +: 7] = glyph[(v >> (4 * k)) & 15];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"},    32'(value),    32'(m_val));
        check({tag, ".tick"},     32'(tick),     32'(m_tick));
        check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
        check({tag, ".seg"},      32'(seg),      32'(m_seg));
        check({tag, ".seg_nb"},   32'(seg_nb),   32'(m_seg_nb));
        check({tag, ".value_nb"}, 32'(value_nb), 32'(m_val));
    endtask

    task automatic model_reset();
        m_val = 0; cyc = 0; m_tick = 1'b0; m_wrap = 1'b0;
        m_seg = '1; m_seg_nb = '1;
    endtask

    // One clock edge: advance the model from pre-edge state, then compare
    task automatic step(input string tag);
        int n;
        @(posedge clock);
        m_seg    = seg_of(m_val, 1'b1);
        m_seg_nb = seg_of(m_val, 1'b0);
        m_wrap   = 1'b0;
        if (clear) begin
            m_val = 0;
        end else if (load) begin
            m_val = bcd ? to_bcd(to_dec(int'(load_value))) : int'(load_value);
        end else if (m_tick && run) begin
            if (bcd) begin
                n      = to_dec(m_val);
                m_wrap = up ? (n == DMOD - 1) : (n == 0);
                m_val  = to_bcd((n + (up ? 1 : DMOD - 1)) % DMOD);
            end else begin
                m_wrap = up ? (m_val == HMOD - 1) : (m_val == 0);
                m_val  = (m_val + (up ? 1 : HMOD - 1)) % HMOD;
            end
        end
        cyc++;
        m_tick = (cyc % PRESCALE) == 0;
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input logic [VW-1:0] v);
        load = 1'b1; load_value = v;
        step("load");
        load = 1'b0;
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();
        #12;
        check_all("reset");
        check("reset.seg_ones", 32'(seg), 32'(14'h3FFF));
        @(negedge clock);
        reset = 1'b1;

        // Hex up counting, then through FF -> 00
        run = 1'b1; up = 1'b1; bcd = 1'b0;
        repeat (24) step("hex_up");
        do_load(8'hFD);
        repeat (16) step("hex_wrap");

        // BCD up across 99 -> 00, and the 09 step in each mode
        bcd = 1'b1;
        do_load(8'h98);
        check("bcd_load98", 32'(value), 32'h98);
        repeat (12) step("bcd_up");
        bcd = 1'b0;
        do_load(8'h09);
        repeat (PRESCALE) step("hex_09");
        check("hex_09_to_0A", 32'(value), 32'h0A);
        bcd = 1'b1;
        do_load(8'h09);
        repeat (PRESCALE) step("bcd_09");
        check("bcd_09_to_10", 32'(value), 32'h10);

        // Down-count wraps and run=0 hold
        up = 1'b0; bcd = 1'b0;
        do_load(8'h00);
        repeat (PRESCALE) step("hex_down");
        check("hex_00_to_FF", 32'(value), 32'hFF);
        bcd = 1'b1;
        do_load(8'h00);
        repeat (PRESCALE) step("bcd_down");
        check("bcd_00_to_99", 32'(value), 32'h99);
        run = 1'b0;
        repeat (3 * PRESCALE) step("hold");
        check("hold_99", 32'(value), 32'h99);

        // Load clamp, clear priority, load beats a tick
        do_load(8'hA7);
        check("bcd_clampA7", 32'(value), 32'h97);
        clear = 1'b1;
        do_load(8'h55);
        clear = 1'b0;
        check("clear_over_load", 32'(value), 32'h00);
        run = 1'b1; up = 1'b1;
        n_wait = 0;
        while (!m_tick && n_wait < 2 * PRESCALE) begin
            step("align");
            n_wait++;
        end
        check("tick_seen", 32'(tick), 32'd1);
        do_load(8'h42);
        check("load_over_tick", 32'(value), 32'h42);

        // Display decode and blanking
        run = 1'b0; bcd = 1'b0;
        do_load(8'h05);
        step("seg05");
        check("seg05.hi", 32'(seg[13:7]), 32'h7F);
        check("seg05.lo", 32'(seg[6:0]), 32'h12);
        check("seg05.hi_nb", 32'(seg_nb[13:7]), 32'h40);
        do_load(8'h00);
        step("seg00");
        check("seg00.lo", 32'(seg[6:0]), 32'h40);
        check("seg00.hi", 32'(seg[13:7]), 32'h7F);
        do_load(8'hF0);
        step("segF0");
        check("segF0.hi", 32'(seg[13:7]), 32'h0E);

        // Asynchronous reset mid-count
        do_load(8'h37);
        step("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clock);
        reset = 1'b1;
        run = 1'b1; up = 1'b1;
        n_wait = 0;
        while (!m_tick && n_wait < 4 * PRESCALE) begin
            step("post_reset");
            n_wait++;
        end
        check("first_tick_delay", 32'(n_wait), 32'(PRESCALE));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            run        = ($urandom_range(0, 9) != 0);
            up         = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) bcd = ~bcd;
            clear      = ($urandom_range(0, 39) == 0);
            load       = ($urandom_range(0, 19) == 0);
            load_value = VW'($urandom);
            step("rand");
        end
        clear = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_display_ctrl.md
Name: counter_display_ctrl

Overview:
Parametrised free-running counter with an integrated seven-segment display driver.
- Generates its own count rate from a prescaler, so no separate clock divider is needed.
- Counts up or down in hex or BCD, with synchronous clear/load and a one-cycle wrap pulse.
- Drives DIGITS active-low seven-segment displays, with optional leading-zero blanking.
- Sits at board top level between CLOCK_50 / KEY inputs and the HEX outputs.

Parameters:
DIGITS, 8, number of 4-bit digits and seven-segment displays (1..8).
PRESCALE, 50000000, clock cycles per count tick (>=1; 1 = tick every cycle).
BLANK_LZ, 1, 1 = blank leading-zero digits (digit 0 is never blanked).

Ports:
clock  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous active-low reset.
run  in  1  1 = count on each tick.
up  in  1  1 = count up, 0 = count down.
bcd  in  1  1 = BCD mode (digits 0-9), 0 = hex mode.
clear  in  1  synchronous clear of value.
load  in  1  synchronous load of load_value.
load_value  in  4*DIGITS  value to load; digit k = bits [4k+3:4k].
value  out  4*DIGITS  current count, registered.
seg  out  7*DIGITS  segments, active-low; digit k: seg[7k]=a ... seg[7k+6]=g.
tick  out  1  one-cycle pulse at each prescaler terminal count.
wrap  out  1  one-cycle pulse when a count step wraps.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - prescaler = 0, value = 0, tick = 0, wrap = 0;
  - seg = all ones (all segments off).
- Prescaler:
  - Free-running 0..PRESCALE-1; runs regardless of run, clear and load.
  - tick is registered and equals 1 in the cycle after the prescaler reaches PRESCALE-1.
  - Width is $clog2(PRESCALE), minimum 1.
- Update priority each cycle: clear > load > count step.
  - clear: value <= 0, wrap <= 0.
  - load, hex mode: value <= load_value.
  - load, BCD mode: each nibble >9 is clamped to 9. wrap <= 0.
  - Count step occurs when tick=1 && run=1 && !clear && !load.
- Hex step: binary ±1 modulo 2^(4*DIGITS).
  - Up from all-F, or down from 0, sets wrap=1 for exactly one cycle, coincident with the new value.
- BCD step: per-digit decimal carry/borrow.
  - Up from all-9s -> 0 with wrap; down from 0 -> all-9s with wrap.
  - Example: up 09 -> 10; down 10 -> 09.
  - A digit >9 on entry (mode switched mid-count) is treated as 9: up yields 0 with carry, down yields 8.
- wrap is 0 in every cycle without a wrapping step.
- Changing up or bcd takes effect on the next step; value is not modified by a mode change.
- seg is registered from value, so it lags value by one cycle.
  - Decode: standard hex glyphs 0-F, active-low.
  - "0" = 7'h40, "5" = 7'h12, "F" = 7'h0E (bit order g..a).
- Blanking (BLANK_LZ=1): digit k>0 shows 7'h7F when it and all higher digits are 0.
  - Digit 0 always displays.
- Reset asserted mid-operation aborts immediately. Counting resumes from 0 with a full prescaler period after release.

Test Plan:
1. DIGITS=2, PRESCALE=4, hex, up, run=1 after reset release -> tick every 4th cycle; value 00,01,02...; from FF the next tick gives 00 with wrap=1 for one cycle only.
2. bcd=1, up, load 8'h98 -> value 98; next two ticks give 99 then 00 with wrap=1; hex mode from 09 gives 0A, BCD mode gives 10.
3. up=0, hex, value 00 -> next tick FF with wrap=1; BCD gives 99 with wrap=1; run=0 -> value holds across 3 ticks while tick keeps pulsing.
4. bcd=1, load_value 8'hA7 -> value 97; clear and load together -> value 00; load in the same cycle as tick -> load wins and no step occurs.
5. BLANK_LZ=1, value 05 -> one cycle later seg[13:7]=7'h7F, seg[6:0]=7'h12; value 00 -> seg[6:0]=7'h40, seg[13:7]=7'h7F; BLANK_LZ=0 -> seg[13:7]=7'h40.
6. reset pulled low mid-count with value 37 -> value, tick and wrap are 0 and seg is all ones without waiting for a clock edge; after release the first tick occurs PRESCALE cycles later.
